// File: rtl/bus_mem_io.sv
// Data-side slave for the 8-bit core: RAM, GPIO and a prescaled compare timer.
// Optional macro BUSIO_GPIO_EDGE_EN adds the GPIO_EDGE rising-edge capture register at 0xF6.
`timescale 1ns/1ps
module bus_mem_io #(
    parameter int RAM_DEPTH = 64,
    parameter int PRESC_DIV = 4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] Addres_Data_Bus,
    input  logic [7:0] DataOut_Bus,
    input  logic       LE,
    output logic [7:0] Datain_Bus,
    input  logic [7:0] gpio_in,
    output logic [7:0] gpio_out,
    output logic       tmr_flag
);

    localparam int         AW        = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [8:0] RAM_LIM   = 9'(RAM_DEPTH);
    localparam logic [7:0] PRESC_MAX = 8'(PRESC_DIV - 1);

    localparam logic [7:0] ADDR_GPIO_OUT = 8'hF0;
    localparam logic [7:0] ADDR_GPIO_IN  = 8'hF1;
    localparam logic [7:0] ADDR_TMR_CNT  = 8'hF2;
    localparam logic [7:0] ADDR_TMR_CMP  = 8'hF3;
    localparam logic [7:0] ADDR_TMR_CTRL = 8'hF4;
    localparam logic [7:0] ADDR_TMR_STAT = 8'hF5;
`ifdef BUSIO_GPIO_EDGE_EN
    localparam logic [7:0] ADDR_GPIO_EDGE = 8'hF6;
`endif

    logic [7:0] mem_r [RAM_DEPTH];
    logic [7:0] gpio_out_r;
    logic [7:0] sync1_r;
    logic [7:0] sync2_r;
    logic [7:0] tmr_cnt_r;
    logic [7:0] tmr_cmp_r;
    logic [7:0] presc_r;
    logic       tmr_en_r;
    logic       tmr_auto_r;
    logic       flag_r;

    logic       ram_hit_s;
    logic [AW-1:0] ram_idx_s;
    logic       wr_gpio_s;
    logic       wr_cmp_s;
    logic       wr_ctrl_s;
    logic       wr_stat_s;
    logic       clr_wr_s;
    logic       tick_s;
    logic       match_s;
    logic       flag_set_s;
    logic       flag_clr_s;
    logic [7:0] rd_data_s;

    assign ram_hit_s  = ({1'b0, Addres_Data_Bus} < RAM_LIM);
    assign ram_idx_s  = Addres_Data_Bus[AW-1:0];
    assign wr_gpio_s  = LE && (Addres_Data_Bus == ADDR_GPIO_OUT);
    assign wr_cmp_s   = LE && (Addres_Data_Bus == ADDR_TMR_CMP);
    assign wr_ctrl_s  = LE && (Addres_Data_Bus == ADDR_TMR_CTRL);
    assign wr_stat_s  = LE && (Addres_Data_Bus == ADDR_TMR_STAT);
    assign clr_wr_s   = wr_ctrl_s && DataOut_Bus[2];
    assign tick_s     = tmr_en_r && (presc_r == PRESC_MAX);
    assign match_s    = (tmr_cnt_r == tmr_cmp_r);
    // A CLR write suppresses the tick entirely, including its compare match.
    assign flag_set_s = tick_s && match_s && !clr_wr_s;
    assign flag_clr_s = wr_stat_s && DataOut_Bus[0];

    // RAM write port; contents are deliberately left unreset
    always_ff @(posedge Clk) begin
        if (LE && ram_hit_s) begin
            mem_r[ram_idx_s] <= DataOut_Bus;
        end
    end

    // GPIO output register and two-flop input synchronizer
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            gpio_out_r <= 8'h00;
            sync1_r    <= 8'h00;
            sync2_r    <= 8'h00;
        end else begin
            sync1_r <= gpio_in;
            sync2_r <= sync1_r;
            if (wr_gpio_s) begin
                gpio_out_r <= DataOut_Bus;
            end
        end
    end

    // Timer configuration registers
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            tmr_cmp_r  <= 8'hFF;
            tmr_en_r   <= 1'b0;
            tmr_auto_r <= 1'b0;
        end else begin
            if (wr_cmp_s) begin
                tmr_cmp_r <= DataOut_Bus;
            end
            if (wr_ctrl_s) begin
                tmr_en_r   <= DataOut_Bus[0];
                tmr_auto_r <= DataOut_Bus[1];
            end
        end
    end

    // Prescaler and timer counter
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            presc_r   <= 8'h00;
            tmr_cnt_r <= 8'h00;
        end else if (clr_wr_s) begin
            presc_r   <= 8'h00;
            tmr_cnt_r <= 8'h00;
        end else if (!tmr_en_r) begin
            presc_r <= 8'h00;
        end else if (tick_s) begin
            presc_r   <= 8'h00;
            tmr_cnt_r <= (match_s && tmr_auto_r) ? 8'h00 : tmr_cnt_r + 8'h01;
        end else begin
            presc_r <= presc_r + 8'h01;
        end
    end

    // Compare flag: a set in the same cycle as write-1-to-clear wins
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            flag_r <= 1'b0;
        end else if (flag_set_s) begin
            flag_r <= 1'b1;
        end else if (flag_clr_s) begin
            flag_r <= 1'b0;
        end else begin
            flag_r <= flag_r;
        end
    end

`ifdef BUSIO_GPIO_EDGE_EN
    logic [7:0] sync_prev_r;
    logic [7:0] edge_r;
    logic [7:0] edge_clr_s;

    assign edge_clr_s = (LE && (Addres_Data_Bus == ADDR_GPIO_EDGE)) ? DataOut_Bus : 8'h00;

    // Rising-edge capture on the synchronized inputs; new edges override clears
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sync_prev_r <= 8'h00;
            edge_r      <= 8'h00;
        end else begin
            sync_prev_r <= sync2_r;
            edge_r      <= (edge_r & ~edge_clr_s) | (sync2_r & ~sync_prev_r);
        end
    end
`endif

    // Combinational read mux so the core captures data in the same cycle
    always_comb begin
        rd_data_s = 8'h00;
        if (ram_hit_s) begin
            rd_data_s = mem_r[ram_idx_s];
        end else begin
            case (Addres_Data_Bus)
                ADDR_GPIO_OUT:  rd_data_s = gpio_out_r;
                ADDR_GPIO_IN:   rd_data_s = sync2_r;
                ADDR_TMR_CNT:   rd_data_s = tmr_cnt_r;
                ADDR_TMR_CMP:   rd_data_s = tmr_cmp_r;
                ADDR_TMR_CTRL:  rd_data_s = {6'b000000, tmr_auto_r, tmr_en_r};
                ADDR_TMR_STAT:  rd_data_s = {7'b0000000, flag_r};
`ifdef BUSIO_GPIO_EDGE_EN
                ADDR_GPIO_EDGE: rd_data_s = edge_r;
`endif
                default:        rd_data_s = 8'h00;
            endcase
        end
    end

    assign Datain_Bus = rd_data_s;
    assign gpio_out   = gpio_out_r;
    assign tmr_flag   = flag_r;

endmodule

// File: doc/bus_mem_io.md
Name: bus_mem_io

Overview:
- Data-side slave that sits directly downstream of the 8-bit microprocessor core.
- Consumes the core's Addres_Data_Bus, DataOut_Bus and LE write strobe, and returns read data on Datain_Bus.
- Provides a small data RAM, a memory-mapped GPIO output/input pair, and an 8-bit prescaled timer with compare flag.
- All register state is clocked. The read path is combinational so the core captures the read value in the same cycle.

Parameters:
- RAM_DEPTH, 64: number of 8-bit RAM words at addresses 0x00..RAM_DEPTH-1. Legal range 1..240.
- PRESC_DIV, 4: timer prescale ratio; one timer tick every PRESC_DIV enabled clocks. Legal range 1..256.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst  input  1  asynchronous reset, active-low.
- Addres_Data_Bus  input  8  data address from core.
- DataOut_Bus  input  8  write data from core.
- LE  input  1  write enable; write occurs on a rising Clk edge while LE=1.
- Datain_Bus  output  8  read data to core; combinational on Addres_Data_Bus.
- gpio_in  input  8  asynchronous external inputs.
- gpio_out  output  8  registered GPIO output.
- tmr_flag  output  1  timer compare flag (mirror of TMR_STAT bit0).

Behaviour:
- Interface: one clock (Clk); reset Rst is asynchronous and active-low.
- Reset (Rst=0): gpio_out=0x00, sync stages=0x00, TMR_CNT=0x00, TMR_CMP=0xFF, TMR_CTRL=0x00, prescaler=0, flag=0, tmr_flag=0. RAM contents are not reset; they are undefined until written.
- Reset mid-operation: all of the above return to reset values immediately. A write in progress is lost.
- Memory map:
  - 0x00..RAM_DEPTH-1: RAM, read/write.
  - 0xF0 GPIO_OUT: read/write.
  - 0xF1 GPIO_IN: read-only, synchronized.
  - 0xF2 TMR_CNT: read-only.
  - 0xF3 TMR_CMP: read/write.
  - 0xF4 TMR_CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 CLR. CLR is write-only and self-clearing; it always reads 0. Bits 7:3 read 0.
  - 0xF5 TMR_STAT: bit0 FLAG; writing 1 clears it. Bits 7:1 read 0.
  - All other addresses, including RAM_DEPTH..0xEF: read 0x00, writes ignored.
- Write timing: data takes effect at the LE=1 clock edge and is visible on Datain_Bus in the following cycle. A read of the same address in the write cycle returns the old value.
- GPIO_IN: two-flop synchronizer. An input change is visible on Datain_Bus after 2 rising edges.
- Prescaler:
  - Counts 0..PRESC_DIV-1 while EN=1.
  - A tick is generated when the prescaler equals PRESC_DIV-1, and the prescaler wraps to 0 on that edge.
  - When EN=0, the prescaler is held at 0 and TMR_CNT holds its value.
- Timer on a tick:
  - If TMR_CNT==TMR_CMP: FLAG<=1, and TMR_CNT<=0 if AUTO_RELOAD=1, else TMR_CNT+1.
  - Otherwise: TMR_CNT<=TMR_CNT+1.
  - Increment wraps 0xFF->0x00 without setting FLAG unless the compare matches.
- Priorities:
  - A CLR write zeroes TMR_CNT and the prescaler, and overrides any tick in the same cycle.
  - A FLAG set in the same cycle as a write-1-to-clear leaves FLAG=1 (set wins).
  - A TMR_CMP write does not alter TMR_CNT. A compare against the new value starts from the next tick.
  - Writing TMR_CTRL with EN=0 and CLR=1 leaves the counter cleared and stopped.
- tmr_flag is the registered FLAG bit; it is not combinationally gated.

Optional Feature:
- Macro: BUSIO_GPIO_EDGE_EN.
- When defined:
  - Adds register 0xF6 GPIO_EDGE, 8 bits.
  - A bit sets when the synchronized gpio_in bit rises (previous synchronized 0, current 1).
  - Writing 1 to a bit clears it; a set in the same cycle wins.
  - Reset value 0x00.
  - Rising-edge detection adds one extra flop stage, so an edge appears 3 edges after the gpio_in change.
- When undefined: 0xF6 behaves as an unmapped address (reads 0x00, writes ignored), and no edge flops are built.

Test Plan:
- Reset, then write 0x5A to 0x00 and 0xA5 to 0x3F (LE=1 one cycle each), then read both -> Datain_Bus 0x5A and 0xA5. Read 0x40 and 0xE0 -> 0x00.
- Write 0xC3 to 0xF0 -> gpio_out=0xC3 after the edge. Read 0xF0 -> 0xC3. Assert Rst=0 mid-cycle -> gpio_out=0x00 immediately.
- Change gpio_in 0x00->0x81 -> read of 0xF1 gives 0x00 for the first edge and 0x81 after the second edge.
- PRESC_DIV=4, write TMR_CMP=0x03, TMR_CTRL=0x03 -> TMR_CNT steps every 4 clocks: 0,1,2,3. FLAG and tmr_flag go 1 on the 4th tick, and TMR_CNT reloads to 0. Write 0x01 to 0xF5 -> FLAG=0.
- AUTO_RELOAD=0, TMR_CMP=0xFF, EN=1 -> count reaches 0xFF, FLAG set, and the next tick wraps to 0x00. A W1C coincident with the match tick -> FLAG stays 1. A CLR write coincident with a tick -> TMR_CNT=0x00.
- With BUSIO_GPIO_EDGE_EN defined: pulse gpio_in[2] 0->1 -> 0xF6 reads 0x04 after 3 edges, then write 0x04 -> 0x00. Without the macro, 0xF6 always reads 0x00.
